// File: rtl/pc_gen.sv
// Program counter generator: exception, stall, redirect, buffered redirect and
// sequential fetch, with target alignment and a misaligned-target pulse.
module pc_gen #(
   parameter int unsigned     WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = {WIDTH{1'b0}},
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0004),
   parameter logic [WIDTH-1:0] STEP      = WIDTH'(32'd4),
   parameter int unsigned     ALIGN_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redir_valid,
   input  logic [WIDTH-1:0] redir_target,
   input  logic             exc_valid,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_next_pc,
   output logic             o_pend,
   output logic             o_misalign
);

   // Bits kept by alignment; all ones when ALIGN_BITS is zero.
   localparam logic [WIDTH-1:0] ALIGN_MASK =
      ~((WIDTH'(1'b1) << ALIGN_BITS) - WIDTH'(1'b1));

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic             pend_q, pend_d;
   logic             misalign_q, misalign_d;
   logic [WIDTH-1:0] aligned_tgt_s;
   logic             tgt_misaligned_s;

   function automatic logic [WIDTH-1:0] align_f(input logic [WIDTH-1:0] tgt);
      return tgt & ALIGN_MASK;
   endfunction

   assign aligned_tgt_s    = align_f(redir_target);
   assign tgt_misaligned_s = |(redir_target & ~ALIGN_MASK);

   // Next-state selection in priority order: exception, stall, redirect, pending, sequential.
   always_comb begin
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      misalign_d = 1'b0;
      if (exc_valid) begin
         pc_d   = EXC_VEC;
         pend_d = 1'b0;
      end else if (stall) begin
         if (redir_valid) begin
            pend_d     = 1'b1;
            pend_tgt_d = aligned_tgt_s;
            misalign_d = tgt_misaligned_s;
         end else begin
            pend_d = pend_q;
         end
      end else if (redir_valid) begin
         pc_d       = aligned_tgt_s;
         pend_d     = 1'b0;
         misalign_d = tgt_misaligned_s;
      end else if (pend_q) begin
         pc_d   = pend_tgt_q;
         pend_d = 1'b0;
      end else begin
         pc_d = pc_q + STEP;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VEC;
         pend_q     <= 1'b0;
         pend_tgt_q <= {WIDTH{1'b0}};
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         misalign_q <= misalign_d;
      end
   end

   assign o_pc       = pc_q;
   assign o_next_pc  = pc_d;
   assign o_pend     = pend_q;
   assign o_misalign = misalign_q;

endmodule
